// File: rtl/fm_pkg.sv
// Shared types and helpers for the FM demodulator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fm_pkg;

  localparam int CARRIER_PINC_WIDTH = 32;
  localparam int SIGNAL_PHASE_WIDTH = 16;
  localparam int LOG2_DECIM_MAX     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } fm_state_e;

  typedef logic signed [SIGNAL_PHASE_WIDTH-1:0] phase_t;

  // Phase difference a - b taken modulo 2^N; the signed result wraps at +/-pi,
  // so a step across the +pi/-pi seam comes out as the short way round.
  function automatic phase_t phase_sub(input phase_t a, input phase_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/fm_accumulate_dump.sv
// Block averager: sums 2^L frequency samples, emits the arithmetic-shifted mean.
// Latency: result registered on the edge that accepts the last sample of a block.
// Backpressure: result held until m_rdy_i; caller must not feed a block-ending sample while full.
module fm_accumulate_dump #(
  parameter int SIGNAL_PHASE_WIDTH = 16,
  parameter int LOG2_DECIM_MAX     = 8,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  localparam int LW = $clog2(LOG2_DECIM_MAX + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 sample_vld_i,
  input  logic signed [SIGNAL_PHASE_WIDTH-1:0] sample_i,
  input  logic [LW-1:0]                        log2_dec_i,
  input  logic                                 m_rdy_i,
  output logic                                 m_vld_o,
  output logic [M_AXIS_TDATA_WIDTH-1:0]        m_dat_o
);

  // Accumulator is wide enough for 2^LOG2_DECIM_MAX full-scale samples.
  localparam int AW = SIGNAL_PHASE_WIDTH + LOG2_DECIM_MAX;
  localparam int CW = LOG2_DECIM_MAX + 1;
  localparam int MW = M_AXIS_TDATA_WIDTH;

  logic signed [AW-1:0] acc_q, acc_d, acc_sum, avg;
  logic [CW-1:0]        count_q, count_d, last_idx;
  logic [LW-1:0]        len_q, len_d, len_sat, len_cur;
  logic                 m_vld_q, m_vld_d, blk_end;
  logic [MW-1:0]        m_dat_q, m_dat_d;

  // Block length: saturate the request, and only adopt it at the first sample of a block.
  always_comb begin
    len_sat  = (log2_dec_i > LW'(LOG2_DECIM_MAX)) ? LW'(LOG2_DECIM_MAX) : log2_dec_i;
    len_cur  = (count_q == '0) ? len_sat : len_q;
    last_idx = (CW'(1) << len_cur) - CW'(1);
    acc_sum  = acc_q + AW'(sample_i);
    avg      = acc_sum >>> len_cur;
    blk_end  = sample_vld_i && (count_q == last_idx);
  end

  // Next-state for counter, accumulator and the output register.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
      m_vld_d = 1'b0;
    end else begin
      if (m_rdy_i) m_vld_d = 1'b0;
      if (sample_vld_i) begin
        if (count_q == '0) len_d = len_sat;
        if (blk_end) begin
          acc_d   = '0;
          count_d = '0;
          m_vld_d = 1'b1;
          m_dat_d = MW'(avg);
        end else begin
          acc_d   = acc_sum;
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
    end
  end

  assign m_vld_o = m_vld_q;
  assign m_dat_o = m_dat_q;

endmodule

// File: rtl/fm_demodulator.sv
// FM demodulator: phase differentiator, carrier removal, block averaging to AXIS.
// Latency: one cycle from the last sample handshake of a block to M_AXIS_tvalid.
// Backpressure: S_AXIS_tready drops while a result waits for M_AXIS_tready.
module fm_demodulator #(
  parameter int CARRIER_PINC_WIDTH = fm_pkg::CARRIER_PINC_WIDTH,
  parameter int SIGNAL_PHASE_WIDTH = fm_pkg::SIGNAL_PHASE_WIDTH,
  parameter int S_AXIS_TDATA_WIDTH = 16,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_DECIM_MAX     = fm_pkg::LOG2_DECIM_MAX
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic                                     fm_enable,
  input  logic [CARRIER_PINC_WIDTH-1:0]            phase_carrier,
  input  logic [$clog2(LOG2_DECIM_MAX+1)-1:0]      log2_decimation,
  input  logic                                     S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]            S_AXIS_tdata,
  output logic                                     S_AXIS_tready,
  input  logic                                     M_AXIS_tready,
  output logic                                     M_AXIS_tvalid,
  output logic [M_AXIS_TDATA_WIDTH-1:0]            M_AXIS_tdata
);

  import fm_pkg::*;

  logic      rst_meta_q, rst_n_q;
  fm_state_e state_q, state_d;
  phase_t    prev_phase_q, prev_phase_d;
  phase_t    x, carrier_phase, delta, freq;
  logic      s_rdy, s_fire, m_vld;
  logic      load_prev, run_vld, blk_clear;
  logic [M_AXIS_TDATA_WIDTH-1:0] m_dat;

  // Only the top phase-width bits of the carrier increment are meaningful here.
  generate
    if (CARRIER_PINC_WIDTH > SIGNAL_PHASE_WIDTH) begin : g_carrier_lsbs
      logic unused_carrier_lsbs;
      assign unused_carrier_lsbs = ^phase_carrier[CARRIER_PINC_WIDTH-SIGNAL_PHASE_WIDTH-1:0];
    end
  endgenerate

  // Reset asserts asynchronously but releases on an aclk edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  assign x             = phase_t'(S_AXIS_tdata[SIGNAL_PHASE_WIDTH-1:0]);
  assign carrier_phase = phase_t'(phase_carrier[CARRIER_PINC_WIDTH-1 -: SIGNAL_PHASE_WIDTH]);
  assign delta         = phase_sub(x, prev_phase_q);
  assign freq          = phase_sub(delta, carrier_phase);
  // While disabled the input is drained unconditionally.
  assign s_rdy         = fm_enable ? (!m_vld || M_AXIS_tready) : 1'b1;
  assign s_fire        = S_AXIS_tvalid && s_rdy;

  // FSM state register and prev_phase.
  always_ff @(posedge aclk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q      <= IDLE;
      prev_phase_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_phase_q <= prev_phase_d;
    end
  end

  // FSM next state: disable forces IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!fm_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (s_fire) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: PRIME only seeds prev_phase, RUN feeds the averager.
  always_comb begin
    load_prev = 1'b0;
    run_vld   = 1'b0;
    blk_clear = 1'b0;
    if (!fm_enable) begin
      blk_clear = 1'b1;
    end else begin
      case (state_q)
        PRIME: load_prev = s_fire;
        RUN: begin
          load_prev = s_fire;
          run_vld   = s_fire;
        end
        default: blk_clear = 1'b1;
      endcase
    end
    prev_phase_d = load_prev ? x : prev_phase_q;
  end

  fm_accumulate_dump #(
    .SIGNAL_PHASE_WIDTH (SIGNAL_PHASE_WIDTH),
    .LOG2_DECIM_MAX     (LOG2_DECIM_MAX),
    .M_AXIS_TDATA_WIDTH (M_AXIS_TDATA_WIDTH)
  ) u_acc_dump (
    .clk_i        (aclk),
    .rst_ni       (rst_n_q),
    .clear_i      (blk_clear),
    .sample_vld_i (run_vld),
    .sample_i     (freq),
    .log2_dec_i   (log2_decimation),
    .m_rdy_i      (M_AXIS_tready),
    .m_vld_o      (m_vld),
    .m_dat_o      (m_dat)
  );

  assign S_AXIS_tready = s_rdy;
  assign M_AXIS_tvalid = m_vld;
  assign M_AXIS_tdata  = m_dat;

endmodule

// File: tb/tb_fm_demodulator.sv
// Directed bench for fm_demodulator: vector table plus hand-written corner sequences.
// Latency: results are checked one edge after the accepting handshake.
// Backpressure: exercised by holding M_AXIS_tready low.
module tb_fm_demodulator;

  logic        aclk = 1'b0;
  logic        aresetn, fm_enable;
  logic [31:0] phase_carrier;
  logic [3:0]  log2_decimation;
  logic        s_vld, s_rdy, m_rdy, m_vld;
  logic [15:0] s_dat;
  logic [31:0] m_dat;

  int n_checks = 0;
  int n_errors = 0;

  logic        rec_en = 1'b0;
  logic [31:0] rec_q[$];

  typedef struct {
    logic        restart;
    logic [3:0]  l2;
    logic [31:0] carrier;
    logic [15:0] phase;
    logic        exp_vld;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];

  always #5 aclk = ~aclk;

  fm_demodulator dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .fm_enable       (fm_enable),
    .phase_carrier   (phase_carrier),
    .log2_decimation (log2_decimation),
    .S_AXIS_tvalid   (s_vld),
    .S_AXIS_tdata    (s_dat),
    .S_AXIS_tready   (s_rdy),
    .M_AXIS_tready   (m_rdy),
    .M_AXIS_tvalid   (m_vld),
    .M_AXIS_tdata    (m_dat)
  );

  // Record every output handshake; inputs only change just after posedge.
  always @(negedge aclk) begin
    if (rec_en && m_vld && m_rdy) rec_q.push_back(m_dat);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic restart_dp;
    fm_enable = 1'b0;
    tick();
    tick();
    fm_enable = 1'b1;
    tick();
    tick();
  endtask

  // Present one sample and return just after the edge that accepts it.
  task automatic send(input logic [15:0] x);
    int n;
    n     = 0;
    s_vld = 1'b1;
    s_dat = x;
    @(negedge aclk);
    while (!s_rdy && n < 40) begin
      @(negedge aclk);
      n++;
    end
    if (!s_rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: S_AXIS_tready=0 required 1 within 40 cycles");
    end
    @(posedge aclk);
    #1;
    s_vld = 1'b0;
  endtask

  task automatic add(input logic rs, input logic [3:0] l2, input logic [31:0] car,
                     input logic [15:0] ph, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.restart = rs; v.l2 = l2; v.carrier = car; v.phase = ph; v.exp_vld = ev; v.exp_dat = ed;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [15:0] ph;
    logic [31:0] bp_exp[4];
    int          early;

    aresetn = 1'b0; fm_enable = 1'b0; phase_carrier = '0; log2_decimation = '0;
    s_vld = 1'b0; s_dat = '0; m_rdy = 1'b1;

    // ---- reset state ----
    tick(); tick();
    chk("rst_m_vld", 32'(m_vld), 32'd0);
    chk("rst_m_dat", m_dat, 32'd0);
    chk("rst_s_rdy", 32'(s_rdy), 32'd1);
    aresetn = 1'b1;
    repeat (4) tick();
    chk("idle_s_rdy", 32'(s_rdy), 32'd1);

    // ---- vector table ----
    // priming + constant frequency, L=0
    add(1, 0, 32'h0, 16'h0000, 0, 32'h0);
    add(0, 0, 32'h0, 16'h0100, 1, 32'h0000_0100);
    add(0, 0, 32'h0, 16'h0200, 1, 32'h0000_0100);
    add(0, 0, 32'h0, 16'h0300, 1, 32'h0000_0100);
    // wrap across +/-pi, then a negative step
    add(1, 0, 32'h0, 16'h7F00, 0, 32'h0);
    add(0, 0, 32'h0, 16'h8100, 1, 32'h0000_0200);
    add(0, 0, 32'h0, 16'h80B0, 1, 32'hFFFF_FFB0);
    // carrier removal and averaging, L=2, f=+4 per sample
    add(1, 2, 32'h0100_0000, 16'h1000, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h1104, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h1208, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h130C, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h1410, 1, 32'h0000_0004);
    add(0, 2, 32'h0100_0000, 16'h1514, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h1618, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h171C, 0, 32'h0);
    add(0, 2, 32'h0100_0000, 16'h1820, 1, 32'h0000_0004);
    // L=1, deltas -3 and -2: sum -5, arithmetic shift gives -3
    add(1, 1, 32'h0, 16'h0010, 0, 32'h0);
    add(0, 1, 32'h0, 16'h000D, 0, 32'h0);
    add(0, 1, 32'h0, 16'h000B, 1, 32'hFFFF_FFFD);
    // carrier larger than delta, and carrier at -pi
    add(1, 0, 32'h0200_0000, 16'h0000, 0, 32'h0);
    add(0, 0, 32'h0200_0000, 16'h0100, 1, 32'hFFFF_FF00);
    add(0, 0, 32'h8000_0000, 16'h0100, 1, 32'hFFFF_8000);

    for (int i = 0; i < tbl.size(); i++) begin
      log2_decimation = tbl[i].l2;
      phase_carrier   = tbl[i].carrier;
      if (tbl[i].restart) restart_dp();
      send(tbl[i].phase);
      chk($sformatf("vec%0d_vld", i), 32'(m_vld), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) chk($sformatf("vec%0d_dat", i), m_dat, tbl[i].exp_dat);
    end

    // ---- backpressure ----
    phase_carrier = '0; log2_decimation = 4'd0;
    restart_dp();
    m_rdy = 1'b0;
    rec_q.delete();
    rec_en = 1'b1;
    send(16'h0000);
    send(16'h0040);
    chk("bp_first_vld", 32'(m_vld), 32'd1);
    chk("bp_first_dat", m_dat, 32'h40);
    s_vld = 1'b1; s_dat = 16'h00C0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("bp_s_rdy%0d", k), 32'(s_rdy), 32'd0);
      chk($sformatf("bp_hold_dat%0d", k), m_dat, 32'h40);
      chk($sformatf("bp_hold_vld%0d", k), 32'(m_vld), 32'd1);
    end
    tick();
    m_rdy = 1'b1;
    send(16'h00C0);
    send(16'h0180);
    send(16'h0280);
    repeat (3) tick();
    rec_en = 1'b0;
    bp_exp[0] = 32'h40; bp_exp[1] = 32'h80; bp_exp[2] = 32'hC0; bp_exp[3] = 32'h100;
    chk("bp_count", 32'(rec_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rec_q.size()) chk($sformatf("bp_order%0d", i), rec_q[i], bp_exp[i]);
    end

    // ---- disable mid-block, L=3 ----
    log2_decimation = 4'd3;
    restart_dp();
    ph = 16'h1000;
    send(ph);
    for (int k = 0; k < 5; k++) begin
      ph = ph + 16'h0010;
      send(ph);
      chk($sformatf("dis_pre_vld%0d", k), 32'(m_vld), 32'd0);
    end
    fm_enable = 1'b0;
    @(negedge aclk);
    chk("dis_s_rdy", 32'(s_rdy), 32'd1);
    chk("dis_m_vld", 32'(m_vld), 32'd0);
    send(16'h5555);
    chk("dis_drain_vld", 32'(m_vld), 32'd0);
    fm_enable = 1'b1;
    tick(); tick();
    ph = 16'h2000;
    send(ph);
    for (int k = 0; k < 8; k++) begin
      ph = ph + 16'(32 + 4 * k);
      send(ph);
      chk($sformatf("dis_post_vld%0d", k), 32'(m_vld), (k == 7) ? 32'd1 : 32'd0);
    end
    chk("dis_post_dat", m_dat, 32'h2E);

    // ---- reset mid-block, L=1 ----
    log2_decimation = 4'd1;
    restart_dp();
    send(16'h0000);
    send(16'h0030);
    send(16'h0080);
    chk("rmb_blk_vld", 32'(m_vld), 32'd1);
    chk("rmb_blk_dat", m_dat, 32'h40);
    send(16'h0090);
    chk("rmb_mid_vld", 32'(m_vld), 32'd0);
    aresetn = 1'b0;
    #2;
    chk("rmb_rst_vld", 32'(m_vld), 32'd0);
    chk("rmb_rst_dat", m_dat, 32'd0);
    chk("rmb_rst_s_rdy", 32'(s_rdy), 32'd1);
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    send(16'h0100);
    send(16'h0110);
    chk("rmb_post_vld0", 32'(m_vld), 32'd0);
    send(16'h0140);
    chk("rmb_post_vld1", 32'(m_vld), 32'd1);
    chk("rmb_post_dat", m_dat, 32'h20);

    // ---- block length change mid-block: 1 -> 3 ----
    log2_decimation = 4'd1;
    restart_dp();
    send(16'h0000);
    send(16'h0010);
    chk("l2chg_s1_vld", 32'(m_vld), 32'd0);
    log2_decimation = 4'd3;
    send(16'h0040);
    chk("l2chg_end_vld", 32'(m_vld), 32'd1);
    chk("l2chg_end_dat", m_dat, 32'h20);
    ph = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      ph = ph + 16'(16 * (k + 1));
      send(ph);
      chk($sformatf("l2chg_nxt_vld%0d", k), 32'(m_vld), (k == 7) ? 32'd1 : 32'd0);
    end
    chk("l2chg_nxt_dat", m_dat, 32'h48);

    // ---- saturation: request 15 means 2^8 samples ----
    log2_decimation = 4'd15;
    restart_dp();
    ph = 16'h4000;
    send(ph);
    early = 0;
    for (int k = 0; k < 256; k++) begin
      ph = ph - 16'd6;
      send(ph);
      if (k < 255 && m_vld) early++;
    end
    chk("sat_no_early", 32'(early), 32'd0);
    chk("sat_vld", 32'(m_vld), 32'd1);
    chk("sat_dat", m_dat, 32'hFFFF_FFFA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fm_demodulator.md
Name: fm_demodulator

Overview:
- Receive-side counterpart of the FM phase-increment path.
- Consumes a stream of signed phase samples from the CORDIC translate stage (atan2 of I/Q) and differentiates phase to recover instantaneous frequency.
- Removes the carrier phase increment, then averages over a programmable power-of-two block (accumulate-and-dump) to emit the demodulated signal on an AXI-Stream master.
- Sits between the CORDIC output and the DMA/FIFO writer.

Parameters:
- CARRIER_PINC_WIDTH, 32, width of the carrier phase-increment word.
- SIGNAL_PHASE_WIDTH, 16, width of the incoming phase samples (two's complement, full scale = ±π).
- S_AXIS_TDATA_WIDTH, 16, slave tdata width. Lower SIGNAL_PHASE_WIDTH bits carry phase.
- M_AXIS_TDATA_WIDTH, 32, master tdata width. Result is sign-extended.
- LOG2_DECIM_MAX, 8, maximum log2 of the averaging block length.

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- fm_enable  in  1  demodulator enable.
- phase_carrier  in  CARRIER_PINC_WIDTH  carrier phase increment per sample. The top SIGNAL_PHASE_WIDTH bits are used.
- log2_decimation  in  $clog2(LOG2_DECIM_MAX+1)  block length = 2^value. Values above LOG2_DECIM_MAX saturate to it.
- S_AXIS_tvalid  in  1  phase sample valid.
- S_AXIS_tdata  in  S_AXIS_TDATA_WIDTH  phase sample.
- S_AXIS_tready  out  1  slave ready.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  result valid.
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  demodulated frequency sample, signed.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, prev_phase=0, acc=0, count=0, M_AXIS_tvalid=0, M_AXIS_tdata=0.
  - S_AXIS_tready=1 while fm_enable=0.
- Input handshake:
  - A sample is accepted when S_AXIS_tvalid && S_AXIS_tready.
  - S_AXIS_tready = fm_enable ? (!M_AXIS_tvalid || M_AXIS_tready) : 1.
- States:
  - IDLE:
    - Entered on reset, or on any cycle with fm_enable=0.
    - Input samples are drained and discarded. acc, count and M_AXIS_tvalid are cleared.
    - A pending unaccepted output is dropped.
    - fm_enable=1 -> PRIME.
  - PRIME: the first accepted sample loads prev_phase only; no delta is computed. -> RUN.
  - RUN: each accepted sample x is processed as follows.
    - delta = x - prev_phase, computed modulo 2^SIGNAL_PHASE_WIDTH and interpreted as signed. This gives natural ±π wrap handling, e.g. 0x7FF0 -> 0x8010 gives +0x20.
    - f = delta - phase_carrier[CARRIER_PINC_WIDTH-1 -: SIGNAL_PHASE_WIDTH], also modulo and signed.
    - prev_phase <= x.
    - acc += sign-extended f. acc width = SIGNAL_PHASE_WIDTH + LOG2_DECIM_MAX, so overflow is impossible.
- Block control:
  - The block length L is latched from log2_decimation when count==0 (at the first sample of each block). Changes mid-block take effect at the next block.
  - On the accepted sample where count==2^L-1, the following happen on the next edge:
    - M_AXIS_tdata <= sign-extend(acc_next >>> L), arithmetic shift.
    - M_AXIS_tvalid <= 1.
    - acc <= 0, count <= 0.
  - Otherwise count increments.
- Latency:
  - M_AXIS_tvalid rises 1 cycle after the handshake of the last sample of a block.
  - With L=0 there is one output per input (after priming), also with 1-cycle latency.
- Output hold:
  - M_AXIS_tvalid stays high and tdata stays stable until M_AXIS_tready.
  - Because of the tready rule, a new result can only complete when the output register is empty or draining in the same cycle. On a simultaneous drain and new result, the new result is loaded and tvalid remains 1.
- phase_carrier changes take effect on the next accepted sample. No resynchronisation is needed.

Decomposition:
- Shared package fm_pkg:
  - widths: CARRIER_PINC_WIDTH, SIGNAL_PHASE_WIDTH, LOG2_DECIM_MAX.
  - state enum {IDLE, PRIME, RUN}.
  - helper function for a signed modulo-2^N phase subtract.
- Natural sub-module: fm_accumulate_dump. It holds the counter, accumulator, shift and output register with its AXIS master handshake.
- The top level holds the state machine, prev_phase and the differentiator.

Test Plan:
- Priming, constant frequency:
  - Stimulus: enable, L=0, phase_carrier=0, phases 0, 0x0100, 0x0200, 0x0300.
  - Required: first sample produces no output; then three outputs of 0x100, each 1 cycle after its input handshake.
- Wrap handling:
  - Stimulus: phases 0x7F00, 0x8100 (L=0, carrier=0).
  - Required: output +0x200, not -0xFE00.
- Carrier removal and averaging:
  - Stimulus: phase_carrier=0x0100_0000, L=2, phases stepping +0x0104 for 9 samples.
  - Required: two outputs, each 0x0004.
- Backpressure:
  - Stimulus: L=0, hold M_AXIS_tready=0 for 5 cycles with S_AXIS_tvalid=1.
  - Required: S_AXIS_tready low after the first result; tdata stable.
  - On release: every result is delivered, in order, with none lost or duplicated.
- Disable / reset mid-block:
  - Stimulus: L=3, fm_enable=0 after 5 samples.
  - Required: no output; S_AXIS_tready=1. Re-enable -> PRIME again, and the next output averages 8 fresh deltas.
  - Repeat with aresetn pulsed mid-block: all outputs immediately return to 0.
- log2_decimation change mid-block:
  - Stimulus: change 1->3 at sample 1 of a block.
  - Required: the current block still ends after 2 samples; the next block spans 8 samples.
